gb_lcd_capture: RTL and testbench

Upstream feeder of the VGA scan-out stage. Samples the Game Boy LCD interface (pixel clock, line latch, frame sync, 2-bit shade) asynchronously in the pll clock domain. Writes each 160x144 pixel into the shared framebuffer at address y*160+x, which is the linear addressing the scan-out reader uses. Reports frame completion and lock status.

---
 rtl/gbvga_pkg.sv | 20 ++
 rtl/gb_sync_edge.sv | 45 ++++
 rtl/gb_lcd_capture.sv | 162 ++++++++++++++++
 tb/tb_gb_lcd_capture.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbvga_pkg.sv
// Constants and types shared by the Game Boy LCD capture and the VGA scan-out.
// Framebuffer addressing is linear: y*160 + x.
package gbvga_pkg;

  localparam int GB_H_PIX   = 160;
  localparam int GB_V_LINES = 144;
  localparam int FB_ADDR_W  = 15;
  localparam int PIX_W      = 2;

  typedef enum logic {
    WAIT_VSYNC,
    ACTIVE
  } cap_state_e;

  // y*160 + x as y<<7 + y<<5 + x; 143*160+159 = 23039 fits in 15 bits
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [7:0] y, input logic [7:0] x);
    return {y, 7'd0} + {2'd0, y, 5'd0} + {7'd0, x};
  endfunction

endpackage

// File: rtl/gb_sync_edge.sv
// Multi-bit synchroniser with registered edge pulses; edge bits and side-band bits share one
// chain depth so side data stays aligned with the pulses (FALL_MASK bit set = falling edge).
module gb_sync_edge #(
  parameter int             STAGES    = 2,
  parameter int             EW        = 3,
  parameter int             DW        = 2,
  parameter logic [EW-1:0]  FALL_MASK = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [EW-1:0] edge_i,
  input  logic [DW-1:0] side_i,
  output logic [EW-1:0] pulse_o,
  output logic [DW-1:0] side_o
);

  localparam int W = EW + DW;

  logic [W-1:0]  chain_q [STAGES];
  logic [W-1:0]  dly_q;
  logic [EW-1:0] pulse_q;
  logic [EW-1:0] last_e;
  logic [EW-1:0] dly_e;

  assign last_e = chain_q[STAGES-1][EW-1:0];
  assign dly_e  = dly_q[EW-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) chain_q[i] <= '0;
      dly_q   <= '0;
      pulse_q <= '0;
    end else begin
      chain_q[0] <= {side_i, edge_i};
      for (int i = 1; i < STAGES; i++) chain_q[i] <= chain_q[i-1];
      dly_q   <= chain_q[STAGES-1];
      pulse_q <= (~last_e & dly_e & FALL_MASK) | (last_e & ~dly_e & ~FALL_MASK);
    end
  end

  // dly_q and pulse_q are loaded from the same chain sample, so they line up
  assign pulse_o = pulse_q;
  assign side_o  = dly_q[W-1:EW];

endmodule

// File: rtl/gb_lcd_capture.sv
// Captures the async Game Boy LCD bus into the framebuffer (addr y*160+x), reports frame_done/locked.
// Optional GBLCD_DOUBLE_BUFFER_EN: wr_bank_o toggles on each frame_done; otherwise tied 0.
module gb_lcd_capture
  import gbvga_pkg::*;
#(
  parameter int H_PIX       = GB_H_PIX,
  parameter int V_LINES     = GB_V_LINES,
  parameter int SYNC_STAGES = 2,
  parameter int INVERT_DATA = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 gb_clk_i,
  input  logic                 gb_hsync_i,
  input  logic                 gb_vsync_i,
  input  logic [PIX_W-1:0]     gb_data_i,
  output logic                 wr_en_o,
  output logic [FB_ADDR_W-1:0] wr_addr_o,
  output logic [PIX_W-1:0]     wr_data_o,
  output logic                 wr_bank_o,
  output logic                 frame_done_o,
  output logic                 locked_o
);

  localparam logic [7:0] H_MAX  = 8'(H_PIX);
  localparam logic [7:0] V_MAX  = 8'(V_LINES);
  localparam logic [7:0] X_LAST = 8'(H_PIX - 1);
  localparam logic [7:0] Y_LAST = 8'(V_LINES - 1);

  logic [2:0]       pulse;
  logic [PIX_W-1:0] data_s;
  logic             vs_rise, hs_rise, px_fall;

  gb_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .EW       (3),
    .DW       (PIX_W),
    .FALL_MASK(3'b001)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_i  (reset_i),
    .edge_i ({gb_vsync_i, gb_hsync_i, gb_clk_i}),
    .side_i (gb_data_i),
    .pulse_o(pulse),
    .side_o (data_s)
  );

  assign {vs_rise, hs_rise, px_fall} = pulse;

  // state      | meaning
  // WAIT_VSYNC | after reset, ignore everything until the first frame sync
  // ACTIVE     | tracking x/y and writing in-range pixels
  cap_state_e       state_q, state_d;
  logic [7:0]       x_q, x_d, y_q, y_d;
  logic             first_q, first_d;
  logic             locked_q, locked_d;
  logic             pix_we_q, pix_we_d;
  logic [7:0]       pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [PIX_W-1:0] pix_data_q, pix_data_d;
  logic             wr_en_q, last_wr_q, frame_done_q;
  logic [FB_ADDR_W-1:0] wr_addr_q;
  logic [PIX_W-1:0] wr_data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= WAIT_VSYNC;
      x_q        <= '0;
      y_q        <= '0;
      first_q    <= 1'b0;
      locked_q   <= 1'b0;
      pix_we_q   <= 1'b0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      pix_data_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      first_q    <= first_d;
      locked_q   <= locked_d;
      pix_we_q   <= pix_we_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      pix_data_q <= pix_data_d;
    end
  end

  // Same-cycle events are applied in order vsync, hsync, pixel on the running next-state values
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    first_d    = first_q;
    locked_d   = locked_q;
    pix_we_d   = 1'b0;
    pix_x_d    = x_q;
    pix_y_d    = y_q;
    pix_data_d = (INVERT_DATA != 0) ? ~data_s : data_s;

    if (last_wr_q) locked_d = 1'b1;

    if (vs_rise) begin
      if (state_q == ACTIVE && y_q < Y_LAST) locked_d = 1'b0;
      state_d = ACTIVE;
      x_d     = '0;
      y_d     = '0;
      first_d = 1'b1;
    end

    if (state_d == ACTIVE) begin
      if (hs_rise) begin
        x_d = '0;
        if (first_d) first_d = 1'b0;
        else if (y_d < V_MAX) y_d = y_d + 8'd1;
      end
      if (px_fall && x_d < H_MAX && y_d < V_MAX) begin
        pix_we_d = 1'b1;
        pix_x_d  = x_d;
        pix_y_d  = y_d;
        x_d      = x_d + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      last_wr_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_en_q      <= pix_we_q;
      if (pix_we_q) begin
        wr_addr_q <= fb_addr(pix_y_q, pix_x_q);
        wr_data_q <= pix_data_q;
      end
      last_wr_q    <= pix_we_q && pix_x_q == X_LAST && pix_y_q == Y_LAST;
      frame_done_q <= last_wr_q;
    end
  end

`ifdef GBLCD_DOUBLE_BUFFER_EN
  logic bank_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)        bank_q <= 1'b0;
    else if (last_wr_q) bank_q <= ~bank_q;
  end

  assign wr_bank_o = bank_q;
`else
  assign wr_bank_o = 1'b0;
`endif

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign frame_done_o = frame_done_q;
  assign locked_o     = locked_q;

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Scoreboard bench for gb_lcd_capture: expected writes are queued as pixels are driven and
// checked (address, shade, arrival cycle) by a monitor on the falling clk edge.
module tb_gb_lcd_capture;

  localparam int S   = 2;
  localparam int LAT = S + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        gb_clk = 1'b1;
  logic        gb_hsync = 1'b0;
  logic        gb_vsync = 1'b0;
  logic [1:0]  gb_data = 2'd0;
  logic        wr_en, wr_bank, frame_done, locked;
  logic [14:0] wr_addr;
  logic [1:0]  wr_data;

  gb_lcd_capture #(.SYNC_STAGES(S)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .gb_clk_i    (gb_clk),
    .gb_hsync_i  (gb_hsync),
    .gb_vsync_i  (gb_vsync),
    .gb_data_i   (gb_data),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .wr_bank_o   (wr_bank),
    .frame_done_o(frame_done),
    .locked_o    (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    logic [1:0]  data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   wr_count = 0;
  int   fd_count = 0;
  int   fd_cyc = -1;
  int   last_wr_cyc = -1;
  int   last_wr_addr = -1;
  int   max_addr = 0;
  logic exp_bank = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!reset && wr_en) begin
      wr_count++;
      last_wr_cyc  = cyc;
      last_wr_addr = int'(wr_addr);
      if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr=%0d data=%0d cyc=%0d, none expected", wr_addr, wr_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data || cyc != e.due) begin
          fails++;
          $display("FAIL write: got addr=%0d data=%0d cyc=%0d, want addr=%0d data=%0d cyc=%0d",
                   wr_addr, wr_data, cyc, e.addr, e.data, e.due);
        end
      end
    end
    if (!reset && frame_done) begin
      fd_count++;
      fd_cyc = cyc;
    end
  end

  task automatic do_vsync(input bit with_hs);
    @(negedge clk);
    gb_vsync = 1'b1;
    if (with_hs) gb_hsync = 1'b1;
    repeat (2) @(negedge clk);
    gb_vsync = 1'b0;
    gb_hsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_hsync();
    @(negedge clk);
    gb_hsync = 1'b1;
    repeat (2) @(negedge clk);
    gb_hsync = 1'b0;
    @(negedge clk);
  endtask

  // A line index outside the frame (>= 144) queues no expectation.
  task automatic do_pix(input int line, input int px, input bit with_hs);
    exp_t e;
    @(negedge clk);
    gb_data = 2'(px % 4);
    @(negedge clk);
    gb_clk = 1'b0;
    if (with_hs) gb_hsync = 1'b1;
    if (line < 144 && px < 160) begin
      e.addr = 15'(line * 160 + px);
      e.data = 2'(px % 4);
      e.due  = cyc + 1 + LAT;
      exp_q.push_back(e);
    end
    repeat (2) @(negedge clk);
    gb_clk   = 1'b1;
    gb_hsync = 1'b0;
  endtask

  task automatic do_line(input int line, input int n);
    do_hsync();
    for (int p = 0; p < n; p++) do_pix(line, p, 1'b0);
  endtask

  task automatic drain();
    repeat (LAT + 6) @(negedge clk);
  endtask

  task automatic frame_completed();
`ifdef GBLCD_DOUBLE_BUFFER_EN
    exp_bank = ~exp_bank;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    tests++; if (wr_addr !== 15'd0) begin fails++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    tests++; if (wr_data !== 2'd0) begin fails++; $display("FAIL reset_wr_data: got %0d want 0", wr_data); end
    tests++; if (wr_bank !== 1'b0) begin fails++; $display("FAIL reset_wr_bank: got %b want 0", wr_bank); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked); end
    reset = 1'b0;
    for (int l = 0; l < 4; l++) do_line(200, 4);
    drain();
    tests++; if (wr_count != 0) begin fails++; $display("FAIL no_vsync_writes: got %0d want 0", wr_count); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL no_vsync_locked: got %b want 0", locked); end
  endtask

  task automatic test_first_line();
    int w0 = wr_count;
    do_vsync(1'b0);
    do_line(0, 160);
    drain();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL line0_pending: got %0d want 0", exp_q.size()); end
    tests++; if (wr_count - w0 != 160) begin fails++; $display("FAIL line0_count: got %0d want 160", wr_count - w0); end
    tests++; if (fd_count != 0) begin fails++; $display("FAIL line0_frame_done: got %0d want 0", fd_count); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL line0_locked: got %b want 0", locked); end
  endtask

  task automatic test_full_frame();
    int w0 = wr_count;
    int f0 = fd_count;
    for (int l = 1; l < 143; l++) do_line(l, 1);
    do_line(143, 160);
    drain();
    frame_completed();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL frame_pending: got %0d want 0", exp_q.size()); end
    tests++; if (wr_count - w0 != 302) begin fails++; $display("FAIL frame_count: got %0d want 302", wr_count - w0); end
    tests++; if (last_wr_addr != 23039) begin fails++; $display("FAIL frame_last_addr: got %0d want 23039", last_wr_addr); end
    tests++; if (fd_count - f0 != 1) begin fails++; $display("FAIL frame_done_count: got %0d want 1", fd_count - f0); end
    tests++; if (fd_cyc != last_wr_cyc + 1) begin fails++; $display("FAIL frame_done_cycle: got %0d want %0d", fd_cyc, last_wr_cyc + 1); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL frame_locked: got %b want 1", locked); end
    tests++; if (wr_bank !== exp_bank) begin fails++; $display("FAIL frame_bank: got %b want %b", wr_bank, exp_bank); end
  endtask

  task automatic test_short_frame();
    int f0 = fd_count;
    do_vsync(1'b0);
    for (int l = 0; l <= 50; l++) do_line(l, 1);
    drain();
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL short_lock_held: got %b want 1", locked); end
    do_vsync(1'b0);
    repeat (8) @(negedge clk);
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL short_locked: got %b want 0", locked); end
    tests++; if (fd_count != f0) begin fails++; $display("FAIL short_frame_done: got %0d want %0d", fd_count, f0); end
    tests++; if (wr_bank !== exp_bank) begin fails++; $display("FAIL short_bank: got %b want %b", wr_bank, exp_bank); end
    do_line(0, 1);
    drain();
    tests++; if (last_wr_addr != 0) begin fails++; $display("FAIL short_restart_addr: got %0d want 0", last_wr_addr); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL short_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    do_vsync(1'b1);
    do_pix(0, 0, 1'b0);
    do_pix(0, 1, 1'b0);
    do_hsync();
    do_pix(1, 0, 1'b0);
    do_pix(2, 0, 1'b1);
    do_pix(2, 1, 1'b0);
    drain();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
    tests++; if (last_wr_addr != 321) begin fails++; $display("FAIL b2b_last_addr: got %0d want 321", last_wr_addr); end
  endtask

  task automatic test_overflow();
    int w0 = wr_count;
    int f0 = fd_count;
    do_vsync(1'b0);
    do_line(0, 170);
    for (int l = 1; l < 143; l++) do_line(l, 1);
    do_line(143, 160);
    for (int l = 144; l < 150; l++) do_line(l, 2);
    drain();
    frame_completed();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL ovf_pending: got %0d want 0", exp_q.size()); end
    tests++; if (wr_count - w0 != 462) begin fails++; $display("FAIL ovf_count: got %0d want 462", wr_count - w0); end
    tests++; if (max_addr > 23039) begin fails++; $display("FAIL ovf_max_addr: got %0d want <= 23039", max_addr); end
    tests++; if (fd_count - f0 != 1) begin fails++; $display("FAIL ovf_frame_done: got %0d want 1", fd_count - f0); end
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL ovf_locked: got %b want 1", locked); end
    tests++; if (wr_bank !== exp_bank) begin fails++; $display("FAIL ovf_bank: got %b want %b", wr_bank, exp_bank); end
  endtask

  task automatic test_reset_mid();
    int w0;
    do_vsync(1'b0);
    do_line(0, 3);
    drain();
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL mid_pre_locked: got %b want 1", locked); end
    @(negedge clk);
    gb_clk = 1'b0;
    #2 reset = 1'b1;
    #1;
    exp_bank = 1'b0;
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL mid_locked: got %b want 0", locked); end
    tests++; if (wr_addr !== 15'd0) begin fails++; $display("FAIL mid_wr_addr: got %0d want 0", wr_addr); end
    tests++; if (wr_bank !== 1'b0) begin fails++; $display("FAIL mid_wr_bank: got %b want 0", wr_bank); end
    @(negedge clk);
    gb_clk = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    w0 = wr_count;
    do_line(200, 4);
    drain();
    tests++; if (wr_count != w0) begin fails++; $display("FAIL mid_wait_vsync: got %0d writes want 0", wr_count - w0); end
    do_vsync(1'b0);
    do_line(0, 2);
    drain();
    tests++; if (last_wr_addr != 1) begin fails++; $display("FAIL mid_restart_addr: got %0d want 1", last_wr_addr); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL mid_pending: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_full_frame();
    test_short_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
